// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared lite16 register-file defaults and register index names
package reg_write_arbiter_pkg;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_DATA_W   = 16;
  typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_idx_e;
endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at ptr, wrapping N-1 -> 0
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          any
);
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        win_idx = PW'((int'(ptr) + k) % N);
        win_oh[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin sharing of the register file write port,
// registered one-hot grant, register enable decode and shared data bus.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REGS-1:0]         reg_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic                        wr_err
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W:0] REG_LIM = (ADDR_W + 1)'(NUM_REGS);
  logic [PTR_W-1:0]   ptr, win_idx;
  logic [NUM_REQ-1:0] win_oh, eligible;
  logic               win_any, sel_ok;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  // the requester granted this cycle sits out the closing edge
  assign eligible = req & ~gnt & {NUM_REQ{~stall}};
  assign sel_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[win_idx*DATA_W +: DATA_W];
  assign sel_ok   = {1'b0, sel_addr} < REG_LIM;
  rr_picker #(.N(NUM_REQ), .PW(PTR_W)) u_pick (
    .req(eligible), .ptr(ptr), .win_oh(win_oh), .win_idx(win_idx), .any(win_any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      reg_en  <= '0;
      wr_data <= '0;
      wr_addr <= '0;
      wr_err  <= 1'b0;
      ptr     <= '0;
    end else if (win_any) begin
      gnt     <= win_oh;
      reg_en  <= sel_ok ? NUM_REGS'(1) << sel_addr : '0;
      wr_err  <= ~sel_ok;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      ptr     <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else begin
      gnt    <= '0;
      reg_en <= '0;
      wr_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios plus random traffic against a
// requester-level reference model, on 8-register and 6-register builds.
module tb_reg_write_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic [N-1:0] req;
  logic [N*3-1:0] req_addr;
  logic [N*16-1:0] req_data;
  logic [N-1:0] g8, g6;
  logic [7:0] e8;
  logic [5:0] e6;
  logic [15:0] d8, d6;
  logic [2:0] a8, a6;
  logic err8, err6;
  int n_cmp = 0, n_err = 0;
  bit p_req [N];
  logic [2:0] p_addr [N];
  logic [15:0] p_data [N];
  int m_ptr, m_last;
  logic [N-1:0] x_gnt;
  logic [7:0] x_en8;
  logic [5:0] x_en6;
  logic [15:0] x_data;
  logic [2:0] x_addr;
  logic x_err6;

  reg_write_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(g8), .reg_en(e8), .wr_data(d8), .wr_addr(a8), .wr_err(err8));
  reg_write_arbiter #(.NUM_REGS(6)) dut6 (
    .clk(clk), .rst(rst), .stall(stall), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(g6), .reg_en(e6), .wr_data(d6), .wr_addr(a6), .wr_err(err6));

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i] = p_req[i];
      req_addr[i*3 +: 3] = p_addr[i];
      req_data[i*16 +: 16] = p_data[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_last = -1;
    x_gnt = '0; x_en8 = '0; x_en6 = '0; x_data = '0; x_addr = '0; x_err6 = 1'b0;
  endtask

  // winner = pending requester closest at or after ptr, ignoring the one granted last cycle
  task automatic model_edge();
    int best, bestd, d;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if (!stall && p_req[i] && i != m_last && d < bestd) begin best = i; bestd = d; end
    end
    if (best < 0) begin
      x_gnt = '0; x_en8 = '0; x_en6 = '0; x_err6 = 1'b0; m_last = -1;
    end else begin
      x_gnt = '0; x_gnt[best] = 1'b1;
      x_addr = p_addr[best]; x_data = p_data[best];
      x_en8 = '0; x_en8[x_addr] = 1'b1;
      x_en6 = '0;
      if (x_addr < 6) x_en6[x_addr] = 1'b1;
      x_err6 = (x_addr >= 6);
      m_ptr = (best + 1) % N; m_last = best;
    end
  endtask

  task automatic check_all();
    chk("gnt8", 32'(g8), 32'(x_gnt));
    chk("en8", 32'(e8), 32'(x_en8));
    chk("data8", 32'(d8), 32'(x_data));
    chk("addr8", 32'(a8), 32'(x_addr));
    chk("err8", 32'(err8), 32'(0));
    chk("gnt6", 32'(g6), 32'(x_gnt));
    chk("en6", 32'(e6), 32'(x_en6));
    chk("data6", 32'(d6), 32'(x_data));
    chk("err6", 32'(err6), 32'(x_err6));
    chk("onehot_gnt", 32'($onehot0(g8)), 32'(1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_req(input int i, input bit r, input logic [2:0] a, input logic [15:0] d);
    p_req[i] = r; p_addr[i] = a; p_data[i] = d;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_gnt"}, 32'(g8), 32'(0));
    chk({tag, "_en"}, 32'(e8), 32'(0));
    chk({tag, "_data"}, 32'(d8), 32'(0));
    chk({tag, "_err"}, 32'(err6), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i), 16'hA0A0 + 16'(i));
    model_reset();
    // reset held with all requesting
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      zero_check("rst_hold");
    end
    rst = 1'b0;
    // held requests rotate 0,1,2,3,0
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("rot_gnt", 32'(g8), 32'(1 << (c % 4)));
      chk("rot_en", 32'(e8), 32'(1 << (c % 4)));
      chk("rot_data", 32'(d8), 32'(16'hA0A0 + 16'(c % 4)));
    end
    // same address contention with ptr=1
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 3'd0, 16'h0);
    set_req(0, 1'b1, 3'd3, 16'h1111);
    set_req(2, 1'b1, 3'd3, 16'h2222);
    cycle();
    chk("same_first_gnt", 32'(g8), 32'h4);
    chk("same_first_en", 32'(e8), 32'h08);
    chk("same_first_data", 32'(d8), 32'h2222);
    p_req[2] = 1'b0;
    cycle();
    chk("same_second_gnt", 32'(g8), 32'h1);
    chk("same_second_data", 32'(d8), 32'h1111);
    p_req[0] = 1'b0;
    cycle();
    // stall blocks arbitration
    stall = 1'b1;
    set_req(1, 1'b1, 3'd5, 16'h5A5A);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("stall_gnt", 32'(g8), 32'h0);
      chk("stall_en", 32'(e8), 32'h0);
    end
    stall = 1'b0;
    cycle();
    chk("unstall_gnt", 32'(g8), 32'h2);
    set_req(1, 1'b0, 3'd0, 16'h0);
    set_req(0, 1'b1, 3'd1, 16'h0F0F);
    set_req(3, 1'b1, 3'd2, 16'hF0F0);
    cycle();
    chk("ptr2_gnt", 32'(g8), 32'h8);
    p_req[3] = 1'b0;
    cycle();
    p_req[0] = 1'b0;
    // out-of-range address on the 6-register build
    set_req(1, 1'b1, 3'd7, 16'hBEEF);
    cycle();
    chk("oor_gnt6", 32'(g6), 32'h2);
    chk("oor_en6", 32'(e6), 32'h0);
    chk("oor_err6", 32'(err6), 32'h1);
    p_req[1] = 1'b0;
    cycle();
    // async reset in the middle of a grant cycle
    set_req(2, 1'b1, 3'd4, 16'h4444);
    cycle();
    chk("mid_gnt", 32'(g8), 32'h4);
    #2 rst = 1'b1;
    #1;
    zero_check("async_rst");
    model_reset();
    @(posedge clk); #1;
    zero_check("async_hold");
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(7 - i), 16'h1000 + 16'(i));
    rst = 1'b0;
    cycle();
    chk("restart_gnt", 32'(g8), 32'h1);
    // random traffic obeying the hold-until-granted handshake
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (x_gnt[i]) p_req[i] = 1'b0;
        if (!p_req[i] && ($urandom % 3) == 0)
          set_req(i, 1'b1, 3'($urandom % 8), 16'($urandom));
      end
      stall = (($urandom % 8) == 0);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
